// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Imported by the loader top and its byte packer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam logic [7:0] MAGIC_BYTE = 8'hA5;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/le_word_packer.sv
// Shifts accepted bytes into a little-endian 32-bit word.
// word_full flags the 4th byte; word_next is the completed word in that cycle.
module le_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // New bytes enter at the top so byte 0 ends up in bits [7:0].
    assign word_next = {byte_in, word_q[31:8]};
    assign word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next;
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a byte stream into the instruction ROM,
// then releases the core from reset once length and checksum agree.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH  = 256,
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MAGIC  = MAGIC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic [15:0]       len_q;
    logic [15:0]       wcnt_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        sum_q;

    logic        accept;
    logic        frame_start;
    logic        data_shift;
    logic [31:0] word_next;
    logic        word_full;
    logic [16:0] len_ext;
    logic        last_word;

    assign accept      = in_valid && in_ready;
    assign frame_start = accept && (state_q == S_IDLE) && (in_byte == MAGIC);
    assign data_shift  = accept && (state_q == S_DATA);
    assign len_ext     = {1'b0, in_byte, len_q[7:0]};
    assign last_word   = (wcnt_q == (len_q - 16'd1));

    le_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (frame_start),
        .shift_en  (data_shift),
        .byte_in   (in_byte),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_byte == MAGIC) begin
                        state_d = S_LEN0;
                    end
                end
                S_LEN0: state_d = S_LEN1;
                S_LEN1: begin
                    if (len_ext > DEPTH_EXT) begin
                        state_d = S_ERR;
                    end else if (len_ext == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_full && last_word) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_d = (in_byte == sum_q) ? S_DONE : S_ERR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Frame bookkeeping and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            sum_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (frame_start) begin
                len_q   <= '0;
                wcnt_q  <= '0;
                waddr_q <= '0;
                sum_q   <= '0;
            end
            if (accept && state_q == S_LEN0) begin
                len_q[7:0] <= in_byte;
            end
            if (accept && state_q == S_LEN1) begin
                len_q[15:8] <= in_byte;
            end
            if (data_shift) begin
                sum_q <= sum_q + in_byte;
                if (word_full) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= waddr_q;
                    imem_wdata <= word_next;
                    waddr_q    <= waddr_q + ADDR_W'(1);
                    wcnt_q     <= wcnt_q + 16'd1;
                end
            end
        end
    end

    // Status flags follow the next state so they rise one cycle after the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            in_ready <= !(state_d == S_DONE || state_d == S_ERR);
            core_rst <= (state_d != S_DONE);
            done     <= (state_d == S_DONE);
            error    <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: expected writes are queued as frames
// are sent and retired by a monitor as imem_we pulses appear.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;
    int we_count = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    logic [7:0] nom [12] = '{8'hA5, 8'h02, 8'h00,
                             8'h93, 8'h00, 8'h50, 8'h00,
                             8'h13, 8'h01, 8'hA0, 8'h00,
                             8'h97};

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_t e;
            we_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
                    fails++;
                    $display("FAIL write got [%0d]=%h want [%0d]=%h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b, input bit stall);
        @(negedge clk);
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_ready got %b want 1 (byte %h)", in_ready, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error}
            !== {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL %s got rdy=%b we=%b a=%0d d=%h crst=%b done=%b err=%b want 1 0 0 0 1 0 0",
                     tag, in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error);
        end
    endtask

    task automatic check_done(input string tag);
        tests++;
        if ({done, core_rst, error} !== 3'b100) begin
            fails++;
            $display("FAIL %s_done got done=%b crst=%b err=%b want 1 0 0",
                     tag, done, core_rst, error);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_writes got %0d pending want 0", tag, exp_q.size());
        end
    endtask

    task automatic push_nominal();
        exp_q.push_back('{addr: 8'd0, data: 32'h00500093});
        exp_q.push_back('{addr: 8'd1, data: 32'h00A00113});
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");
    endtask

    task automatic test_nominal(input bit stall, input string tag);
        do_reset();
        push_nominal();
        for (int i = 0; i < 12; i++) send(nom[i], stall);
        @(negedge clk);
        check_done(tag);
    endtask

    task automatic test_bad_csum();
        do_reset();
        push_nominal();
        for (int i = 0; i < 11; i++) send(nom[i], 1'b0);
        send(8'h96, 1'b0);
        @(negedge clk);
        tests++;
        if ({error, core_rst, done, in_ready} !== 4'b1100) begin
            fails++;
            $display("FAIL bad_csum got err=%b crst=%b done=%b rdy=%b want 1 1 0 0",
                     error, core_rst, done, in_ready);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL bad_csum_writes got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_oversize();
        int w0;
        do_reset();
        w0 = we_count;
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        @(negedge clk);
        tests++;
        if ({error, done, core_rst, in_ready} !== 4'b1010) begin
            fails++;
            $display("FAIL oversize got err=%b done=%b crst=%b rdy=%b want 1 0 1 0",
                     error, done, core_rst, in_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (we_count != w0) begin
            fails++;
            $display("FAIL oversize_writes got %0d want 0", we_count - w0);
        end
    endtask

    task automatic test_junk_zero_len();
        int w0;
        logic [7:0] s [6] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        do_reset();
        w0 = we_count;
        for (int i = 0; i < 6; i++) send(s[i], 1'b0);
        @(negedge clk);
        check_done("junk_zero");
        tests++;
        if (we_count != w0) begin
            fails++;
            $display("FAIL junk_zero_writes got %0d want 0", we_count - w0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 6; i++) send(nom[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        rst = 1'b0;
        push_nominal();
        for (int i = 0; i < 12; i++) send(nom[i], 1'b0);
        @(negedge clk);
        check_done("mid_reset_reload");
    endtask

    task automatic test_full_depth();
        int w0;
        logic [7:0]  sum;
        logic [31:0] w;
        do_reset();
        w0  = we_count;
        sum = 8'h00;
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'(i + 7)};
            exp_q.push_back('{addr: 8'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                sum = sum + w[8*k +: 8];
                send(w[8*k +: 8], 1'b0);
            end
        end
        send(sum, 1'b0);
        @(negedge clk);
        check_done("full_depth");
        repeat (3) @(negedge clk);
        tests++;
        if (we_count - w0 != 256) begin
            fails++;
            $display("FAIL full_depth_count got %0d want 256", we_count - w0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal(1'b0, "nominal");
        test_bad_csum();
        test_oversize();
        test_junk_zero_len();
        test_nominal(1'b1, "stall");
        test_mid_reset();
        test_full_depth();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the 5-stage RISC-V pipeline. It receives a framed little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit words, and writes them sequentially into the instruction ROM array through a word-indexed write port. It holds the core in reset until a complete frame passes length and checksum checks, then releases it.

## Interface
Parameters:
- DEPTH, 256, instruction memory depth in words
- ADDR_W, 8, word-index width, equal to $clog2(DEPTH)
- MAGIC, 8'hA5, frame start byte

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  a byte is offered on in_byte
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word index of the write
- imem_wdata  out  32  word to write
- core_rst  out  1  reset to the pipeline; high until a load succeeds
- done  out  1  sticky; the frame was loaded and its checksum matched
- error  out  1  sticky; the frame was rejected

## Operation
- A byte is accepted in a cycle when in_valid && in_ready are both high. Nothing else advances the frame.
- Frame format: MAGIC, LEN[7:0], LEN[15:8], then LEN×4 payload bytes (each word little-endian, byte 0 = bits [7:0]), then CSUM.
- CSUM = 8-bit sum, mod 256, of the payload bytes only. Header bytes are excluded.
- FSM states: S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR.
  - S_IDLE: an accepted byte equal to MAGIC goes to S_LEN0. Any other byte is consumed and discarded.
  - S_LEN0: latch the LEN low byte, go to S_LEN1.
  - S_LEN1: latch the LEN high byte.
    - LEN > DEPTH: go to S_ERR.
    - LEN == 0: go to S_CSUM.
    - Otherwise: go to S_DATA.
  - S_DATA: shift bytes in with a 2-bit byte counter. On the 4th byte of a word:
    - issue a write;
    - increment the word index;
    - after word LEN-1, go to S_CSUM.
  - S_CSUM: accepted byte equal to the running sum goes to S_DONE; otherwise go to S_ERR.
  - S_DONE and S_ERR: terminal until rst.
- in_ready is 1 in S_IDLE through S_CSUM and 0 in S_DONE and S_ERR.
- Word index starts at 0 for every frame. Words beyond LEN are never written, and memory contents past LEN are left untouched.
- LEN == DEPTH is legal. The word index wraps to 0 after the last write, but no further write occurs.
- In S_ERR, core_rst stays 1, and a rejected frame may already have written earlier words.

## Timing
Reset values:
- state = S_IDLE
- in_ready = 1
- imem_we = 0
- imem_addr = 0
- imem_wdata = 0
- core_rst = 1
- done = 0
- error = 0
- running sum = 0
- byte counter = 0

Write timing:
- All outputs are registered.
- imem_we pulses high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- imem_addr and imem_wdata are valid in that same cycle.
- Back-to-back bytes at one per cycle sustain one word write every 4 cycles.

Completion timing:
- done rises and core_rst falls in the cycle after a matching CSUM byte is accepted. From then on they hold.
- error rises in the cycle after a bad CSUM byte, or after the LEN1 byte when LEN > DEPTH.

Handshake:
- in_valid low stalls the frame with no state change.
- in_byte is sampled only on an accepted byte.

Reset:
- rst mid-frame aborts the frame.
- At the next edge, all registers take their reset values, and a pending imem_we is cancelled.
- Memory already written is not cleared.

## Structure
- Shared package imem_loader_pkg holds:
  - typedef enum logic [2:0] loader_state_t for the states above;
  - localparam MAGIC_BYTE = 8'hA5;
  - localparam WORD_BYTES = 4.
- One sub-module, le_word_packer, is natural. It shifts bytes into a little-endian 32-bit word and flags word_full on the 4th accepted byte.
- The FSM, LEN check, checksum and address counter stay in imem_loader.

## Test plan
- Nominal 2-word frame:
  - Stimulus: stream A5 02 00 93 00 50 00 13 01 A0 00 97.
  - Writes: [0]=0x00500093, then [1]=0x00A00113, each as a single-cycle imem_we.
  - Completion: done=1, core_rst=0, error=0.
- Bad checksum:
  - Stimulus: same frame with final byte 96.
  - Required response: both words written, error=1, core_rst=1, done=0, in_ready=0.
- Oversized length:
  - Stimulus: A5 01 01, i.e. LEN=257 with DEPTH=256.
  - Required response: error=1 the cycle after the 3rd byte; no imem_we ever asserted.
- Leading junk and zero length:
  - Stimulus: 00 FF A5 00 00 00.
  - Required response: junk discarded, no writes, done=1, core_rst=0.
- Stalls:
  - Stimulus: nominal frame with in_valid randomly deasserted.
  - Required response: identical writes and completion to the nominal case.
- Reset mid-frame:
  - Stimulus: assert rst after byte 6 of the nominal frame, then resend the full frame.
  - Required response: all outputs at reset values after the reset edge; the reload writes [0] and [1] correctly and ends with done=1.
